// File: rtl/xor_checksum_if.sv
// xor_checksum_if: word stream in, checksum result out, each with a valid/ready handshake.
// The block drives the slave side and its producer/consumer drive the master side.
interface xor_checksum_if #(
    parameter int WIDTH   = 8,
    parameter int MAX_LEN = 16
);
    localparam int CNTW = $clog2(MAX_LEN + 1);
    logic [WIDTH-1:0] in_data;
    logic             in_valid;
    logic             in_last;
    logic             in_ready;
    logic [WIDTH-1:0] out_sum;
    logic [CNTW-1:0]  out_count;
    logic             out_overflow;
    logic             out_valid;
    logic             out_ready;
    modport master (
        output in_data, in_valid, in_last, out_ready,
        input  in_ready, out_sum, out_count, out_overflow, out_valid
    );
    modport slave (
        input  in_data, in_valid, in_last, out_ready,
        output in_ready, out_sum, out_count, out_overflow, out_valid
    );
endinterface

// File: rtl/xor_checksum.sv
// xor_checksum: XORs the words of a frame and counts them (saturating, with overflow flag).
// Defining XOR_CHECKSUM_PARITY_EN adds an out_parity port: the reduction XOR of out_sum.
module xor_checksum #(
    parameter  int WIDTH   = 8,
    parameter  int MAX_LEN = 16,
    localparam int CNTW    = $clog2(MAX_LEN + 1)
) (
    input logic           clk,
    input logic           rst,
    xor_checksum_if.slave bus
`ifdef XOR_CHECKSUM_PARITY_EN
    ,
    output logic          out_parity
`endif
);
    typedef enum logic [1:0] {IDLE, ACCUM, HOLD} state_t;
    state_t           state_q;
    logic [WIDTH-1:0] acc_q;
    logic [CNTW-1:0]  cnt_q;
    logic             ovf_q;
    logic             accept;
    assign bus.in_ready     = state_q != HOLD;
    assign bus.out_valid    = state_q == HOLD;
    assign bus.out_sum      = acc_q;
    assign bus.out_count    = cnt_q;
    assign bus.out_overflow = ovf_q;
    assign accept           = bus.in_valid && bus.in_ready;
`ifdef XOR_CHECKSUM_PARITY_EN
    assign out_parity = ^acc_q;
`endif
    // Outputs keep showing the last frame in IDLE; only a new first word clears them.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= IDLE;
            acc_q   <= '0;
            cnt_q   <= '0;
            ovf_q   <= 1'b0;
        end else begin
            case (state_q)
                IDLE: if (accept) begin
                    acc_q   <= bus.in_data;
                    cnt_q   <= CNTW'(1);
                    ovf_q   <= 1'b0;
                    state_q <= bus.in_last ? HOLD : ACCUM;
                end
                ACCUM: if (accept) begin
                    acc_q <= acc_q ^ bus.in_data;
                    if (cnt_q < CNTW'(MAX_LEN)) cnt_q <= cnt_q + CNTW'(1);
                    else ovf_q <= 1'b1;
                    if (bus.in_last) state_q <= HOLD;
                end
                HOLD: if (bus.out_ready) state_q <= IDLE;
                default: state_q <= IDLE;
            endcase
        end
    end
endmodule

// File: doc/xor_checksum.md
XOR_CHECKSUM -- requirements
Module: xor_checksum

Interface
REQ-001 Parameter WIDTH, default 8: bit width of data words and checksum; SHALL be >= 1.
REQ-002 Parameter MAX_LEN, default 16: frame length at which the word count saturates; SHALL be >= 1.
REQ-003 Derived CNTW = $clog2(MAX_LEN+1): width of the word-count output.
REQ-004 clk  input  1  sole clock; all state updates on its rising edge.
REQ-005 rst  input  1  asynchronous, active-high reset.
REQ-006 in_data  input  WIDTH  data word.
REQ-007 in_valid  input  1  in_data/in_last are valid.
REQ-008 in_last  input  1  current word is the final word of the frame.
REQ-009 in_ready  output  1  block can accept a word.
REQ-010 out_sum  output  WIDTH  XOR of all words in the frame.
REQ-011 out_count  output  CNTW  words in the frame, saturating at MAX_LEN.
REQ-012 out_overflow  output  1  frame exceeded MAX_LEN words.
REQ-013 out_valid  output  1  out_sum/out_count/out_overflow hold a completed frame.
REQ-014 out_ready  input  1  consumer takes the result.

Function
REQ-015 FSM states: IDLE, ACCUM, HOLD; rst forces IDLE.
REQ-016 in_ready = 1 in IDLE and ACCUM, 0 in HOLD; combinational from state only.
REQ-017 Accept = in_valid & in_ready; words presented in HOLD are ignored, with no state change.
REQ-018 Accept in IDLE: acc <= in_data, count <= 1, ovf <= 0; next state HOLD if in_last, else ACCUM.
REQ-019 Accept in ACCUM: acc <= acc ^ in_data; count <= count+1 if count < MAX_LEN, else unchanged; next state HOLD if in_last.
REQ-020 Accept in ACCUM with count == MAX_LEN SHALL set ovf <= 1 (sticky until next frame start). The word is still XORed into acc.
REQ-021 No accept: acc, count, ovf and state are unchanged (gaps of in_valid = 0 allowed mid-frame).
REQ-022 out_valid = 1 exactly while in HOLD, i.e. from the cycle after the last-word accept.
REQ-023 Latency: last word accepted at edge N, so out_valid = 1 and the result is valid after edge N.
REQ-024 HOLD: outputs stable until out_valid & out_ready; next state IDLE; in_ready rises the following cycle.
REQ-025 out_sum/out_count/out_overflow driven directly from acc/count/ovf. They retain the last frame in IDLE until the next IDLE accept.
REQ-026 Single-word frame (in_last on first word): out_sum = word, out_count = 1, out_overflow = 0.
REQ-027 MAX_LEN = 1: second word sets overflow; count stays 1.

Reset
REQ-028 rst asserted: immediately (without waiting for clk) state = IDLE, acc = 0, count = 0, ovf = 0. Therefore out_valid = 0, in_ready = 1, out_sum = 0, out_count = 0, out_overflow = 0.
REQ-029 Reset mid-frame or in HOLD discards the partial or pending result. No output pulse on release.
REQ-030 Reset release is synchronous to clk by the surrounding design. The first accept is possible at the first edge with rst low.

Configuration
REQ-031 Macro XOR_CHECKSUM_PARITY_EN.
- Defined: adds port out_parity (output 1) = reduction XOR of out_sum, combinational, 0 after reset.
- Undefined: port absent; all other behaviour identical.

Verification (WIDTH=8, MAX_LEN=4)
REQ-032 Frame 0x0F, 0xF0, 0x3C (last), out_ready=1 -> out_valid one cycle after last accept; out_sum=0xC3, out_count=3, out_overflow=0; IDLE next cycle.
REQ-033 Single word 0xA5 with in_last -> out_sum=0xA5, out_count=1, out_overflow=0.
REQ-034 Frame 0x01..0x06 (6 words, last on 0x06) -> out_sum=0x07, out_count=4, out_overflow=1.
REQ-035 Result pending, out_ready=0 for 5 cycles while in_valid=1, in_data=0xFF -> out_valid and outputs stable, in_ready=0, no accept; out_ready=1 -> IDLE, in_ready=1 next cycle, and the next frame starts clean.
REQ-036 rst pulsed asynchronously mid-cycle after 2 words accepted -> outputs 0 and in_ready=1 before the next edge; then frame 0x55 (last) -> out_sum=0x55, out_count=1.
REQ-037 With XOR_CHECKSUM_PARITY_EN -> out_parity=0 for sum 0xC3, out_parity=1 for sum 0x07. Build without the macro elaborates without out_parity.
